// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority over long-latency results.
// Long-latency results wait in a small FIFO. A pending scoreboard marks destination registers still in flight.
module writeback_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = 32,
  parameter int RA_W       = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pipe_valid,
  input  logic [RA_W-1:0]               pipe_rd,
  input  logic [XLEN-1:0]               pipe_data,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [RA_W-1:0]               lu_rd,
  input  logic [XLEN-1:0]               lu_data,
  input  logic                          issue_valid,
  input  logic [RA_W-1:0]               issue_rd,
  input  logic [RA_W-1:0]               rs1,
  input  logic [RA_W-1:0]               rs2,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  output logic                          we,
  output logic [RA_W-1:0]               writeIndex,
  output logic [XLEN-1:0]               data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          sb_err
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << RA_W;

  logic [RA_W-1:0] rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem [FIFO_DEPTH];

  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic [NREG-1:0] pending_reg, pending_next;
  logic            sb_err_reg, sb_err_next;

  logic            push, pop, pipe_sel;
  logic [RA_W-1:0] head_rd;
  logic [XLEN-1:0] head_data;

  // Acceptance looks only at the current count, so a full FIFO refuses even on a popping edge.
  assign lu_ready  = rst_n & (count_reg < CW'(FIFO_DEPTH));
  assign push      = lu_valid & lu_ready & (lu_rd != '0);
  assign pipe_sel  = pipe_valid & (pipe_rd != '0);
  assign pop       = ~pipe_sel & (count_reg != '0);
  assign head_rd   = rd_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  assign fifo_count = count_reg;
  assign sb_err     = sb_err_reg;
  assign rs1_busy   = pending_reg[rs1] & (rs1 != '0);
  assign rs2_busy   = pending_reg[rs2] & (rs2 != '0);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Clear for the popped head first, so an issue to the same register on this edge wins.
  always_comb begin
    pending_next = pending_reg;
    sb_err_next  = sb_err_reg;
    if (pop) begin
      pending_next[head_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      pending_next[issue_rd] = 1'b1;
      if (pending_reg[issue_rd]) begin
        sb_err_next = 1'b1;
      end
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= lu_rd;
      data_mem[wr_ptr_reg] <= lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      pending_reg <= '0;
      sb_err_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg   <= count_next;
      pending_reg <= pending_next;
      sb_err_reg  <= sb_err_next;
    end
  end

  // writeIndex/data hold their last values on idle cycles; only we drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we         <= 1'b0;
      writeIndex <= '0;
      data       <= '0;
    end else if (pipe_sel) begin
      we         <= 1'b1;
      writeIndex <= pipe_rd;
      data       <= pipe_data;
    end else if (pop) begin
      we         <= 1'b1;
      writeIndex <= head_rd;
      data       <= head_data;
    end else begin
      we         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and randomized bench for writeback_arbiter, checked against a queue-based reference model.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_valid, lu_valid, issue_valid;
  logic [4:0]  pipe_rd, lu_rd, issue_rd, rs1, rs2;
  logic [31:0] pipe_data, lu_data;
  logic        lu_ready, rs1_busy, rs2_busy, we, sb_err;
  logic [4:0]  writeIndex;
  logic [31:0] data;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  writeback_arbiter #(.FIFO_DEPTH(4), .XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we(we), .writeIndex(writeIndex), .data(data),
    .fifo_count(fifo_count), .sb_err(sb_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pend;
  logic        m_sb, m_we, m_acc;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle();
    pipe_valid  = 1'b0;
    lu_valid    = 1'b0;
    issue_valid = 1'b0;
  endtask

  // Apply the current inputs for one clock edge, advance the model, then compare everything.
  task automatic cycle();
    logic [31:0] pend_old;
    ent_t        e;
    m_acc    = rst_n && lu_valid && (m_q.size() < 4);
    pend_old = m_pend;
    if (!rst_n) begin
      m_q.delete();
      m_pend = '0; m_sb = 1'b0; m_we = 1'b0; m_idx = '0; m_data = '0;
    end else begin
      if (pipe_valid && pipe_rd != 0) begin
        m_we = 1'b1; m_idx = pipe_rd; m_data = pipe_data;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_we = 1'b1; m_idx = e.rd; m_data = e.d;
        m_pend[e.rd] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (m_acc && lu_rd != 0) m_q.push_back('{rd: lu_rd, d: lu_data});
      if (issue_valid && issue_rd != 0) begin
        if (pend_old[issue_rd]) m_sb = 1'b1;
        m_pend[issue_rd] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("we", we, m_we);
    chk("writeIndex", writeIndex, m_idx);
    chk("data", data, m_data);
    chk("fifo_count", fifo_count, m_q.size());
    chk("sb_err", sb_err, m_sb);
    chk("lu_ready", lu_ready, rst_n && (m_q.size() < 4));
    chk("rs1_busy", rs1_busy, m_pend[rs1] && rs1 != 0);
    chk("rs2_busy", rs2_busy, m_pend[rs2] && rs2 != 0);
  endtask

  task automatic randomize_inputs();
    pipe_valid  = 1'($urandom_range(0, 1));
    pipe_rd     = 5'($urandom_range(0, 31));
    pipe_data   = $urandom;
    lu_valid    = 1'($urandom_range(0, 1));
    lu_rd       = 5'($urandom_range(0, 31));
    lu_data     = $urandom;
    issue_valid = 1'($urandom_range(0, 1));
    issue_rd    = 5'($urandom_range(0, 31));
    rs1         = 5'($urandom_range(0, 31));
    rs2         = 5'($urandom_range(0, 31));
  endtask

  initial begin
    int sent;
    m_pend = '0; m_sb = 1'b0; m_we = 1'b0; m_idx = '0; m_data = '0; m_acc = 1'b0;

    // Reset held with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      cycle();
    end
    chk("rst_we", we, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    rst_n = 1'b1;
    idle();
    rs1 = 5'd7; rs2 = 5'd9;
    cycle();

    // Pipeline-only writes, including a dropped write to x0
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    cycle();
    chk("pipe_we", we, 1'b1);
    chk("pipe_idx", writeIndex, 5'd5);
    chk("pipe_data", data, 32'hDEADBEEF);
    pipe_rd = 5'd0; pipe_data = 32'h11111111;
    cycle();
    chk("pipe_x0_we", we, 1'b0);
    idle();
    cycle();

    // Scoreboard round trip on rd=7
    issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
    cycle();
    chk("sb_busy_set", rs1_busy, 1'b1);
    idle();
    cycle();
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h1234;
    cycle();
    chk("sb_busy_held", rs1_busy, 1'b1);
    chk("sb_no_bypass", we, 1'b0);
    idle();
    cycle();
    chk("sb_write_we", we, 1'b1);
    chk("sb_write_data", data, 32'h1234);
    chk("sb_busy_clear", rs1_busy, 1'b0);
    cycle();

    // Contention: pipeline busy every cycle while five long-latency results are offered
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      pipe_valid = 1'b1; pipe_rd = 5'($urandom_range(1, 31)); pipe_data = $urandom;
      lu_valid = (sent < 5); lu_rd = 5'(10 + sent); lu_data = 32'hA000 + 32'(sent);
      cycle();
      if (m_acc) sent++;
      if (c == 5) chk("cont_full_ready", lu_ready, 1'b0);
    end
    pipe_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      lu_valid = (sent < 5); lu_rd = 5'(10 + sent); lu_data = 32'hA000 + 32'(sent);
      cycle();
      if (m_acc) sent++;
    end
    chk("cont_drained", fifo_count, 3'd0);

    // Ten back-to-back pushes with a pop every cycle; rd=9 re-issued as it pops
    idle();
    rs2 = 5'd9;
    for (int j = 0; j < 10; j++) begin
      lu_valid = 1'b1; lu_rd = (j == 4) ? 5'd9 : 5'(20 + j); lu_data = $urandom;
      issue_valid = (j == 5); issue_rd = 5'd9;
      cycle();
      if (j >= 1) chk("wrap_count", fifo_count, 3'd1);
    end
    idle();
    cycle();
    chk("simul_set_wins", rs2_busy, 1'b1);

    // Double issue, then reset with entries buffered
    issue_valid = 1'b1; issue_rd = 5'd3;
    cycle();
    cycle();
    chk("double_issue", sb_err, 1'b1);
    idle();
    for (int j = 0; j < 3; j++) begin
      pipe_valid = 1'b1; pipe_rd = 5'(1 + j); pipe_data = $urandom;
      lu_valid = 1'b1; lu_rd = 5'(16 + j); lu_data = $urandom;
      cycle();
    end
    chk("buffered3", fifo_count, 3'd3);
    idle();
    rst_n = 1'b0;
    cycle();
    chk("rst_mid_count", fifo_count, 3'd0);
    chk("rst_mid_sb", sb_err, 1'b0);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk("rst_mid_no_we", we, 1'b0);
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) issue_valid = 1'b0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
